// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational RV32I ALU among NREQ requesters.
//
// Requests are granted round-robin and handshaken with valid/ready. A granted
// request drives the ALU in the same cycle. Its result and flags are captured
// into a single-entry response register, which is visible the following cycle.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid/req_ready      per-requester handshake (req_ready one-hot or zero)
//   req_srcA/srcB/ctrl       flattened operand and control slices, one per requester
//   alu_srcA/srcB/ctrl       operands and control driven to the ALU
//   alu_result/alu_flags     ALU outputs, flags ordered {ovf, carry, neg, zero}
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/result/flags      registered response and its owning requester
//   busy                     a response is pending (same as rsp_valid)
//
// Optional feature (macro ALU_ARB_LOCK_EN): adds input req_lock. A fire that has
// req_lock set pins the grant to that requester until it fires with req_lock
// clear. Without the macro, the arbiter is pure round-robin.
//
// state | meaning
// EMPTY | no response held, rsp_valid=0
// FULL  | response held,    rsp_valid=1

module alu_arbiter #(
  parameter int XLEN = 32,
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_srcA,
  input  logic [NREQ*XLEN-1:0] req_srcB,
  input  logic [NREQ*5-1:0]    req_ctrl,
`ifdef ALU_ARB_LOCK_EN
  input  logic [NREQ-1:0]      req_lock,
`endif
  output logic [XLEN-1:0]      alu_srcA,
  output logic [XLEN-1:0]      alu_srcB,
  output logic [4:0]           alu_ctrl,
  input  logic [XLEN-1:0]      alu_result,
  input  logic [3:0]           alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [XLEN-1:0]      rsp_result,
  output logic [3:0]           rsp_flags,
  output logic                 busy
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]      rsp_flags_q, rsp_flags_d;

  logic            can_issue;
  logic [NREQ-1:0] elig;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  gnt_next;
  logic [IDW-1:0]  sel_idx;

`ifdef ALU_ARB_LOCK_EN
  logic            lock_q, lock_d;
  logic [IDW-1:0]  lock_id_q, lock_id_d;
`endif

  // A new op may issue when the buffer is empty or is being drained this cycle.
  assign can_issue = (state_q == EMPTY) || rsp_ready;

  always_comb begin
    elig = req_valid;
`ifdef ALU_ARB_LOCK_EN
    if (lock_q) elig = req_valid & (NREQ'(1) << lock_id_q);
`endif
  end

  // Search from rr_ptr upward, wrapping modulo NREQ (NREQ need not be a power of 2).
  always_comb begin : p_grant
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (can_issue) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!gnt_vld && elig[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = IDW'(idx);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[gnt_idx] = 1'b1;
  end

  // With no grant, keep driving the pointer's slice so the mux select is never unknown.
  assign sel_idx  = gnt_vld ? gnt_idx : rr_ptr_q;
  assign alu_srcA = req_srcA[int'(sel_idx)*XLEN +: XLEN];
  assign alu_srcB = req_srcB[int'(sel_idx)*XLEN +: XLEN];
  assign alu_ctrl = req_ctrl[int'(sel_idx)*5 +: 5];

  assign gnt_next = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
`ifdef ALU_ARB_LOCK_EN
    lock_d       = lock_q;
    lock_id_d    = lock_id_q;
`endif
    case (state_q)
      EMPTY:   if (gnt_vld) state_d = FULL;
      FULL:    if (!gnt_vld && rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (gnt_vld) begin
      rsp_id_d     = gnt_idx;
      rsp_result_d = alu_result;
      rsp_flags_d  = alu_flags;
`ifdef ALU_ARB_LOCK_EN
      // The pointer only moves when a lock is not (re)asserted by this fire.
      if (req_lock[gnt_idx]) begin
        lock_d    = 1'b1;
        lock_id_d = gnt_idx;
      end else begin
        lock_d    = 1'b0;
        rr_ptr_d  = gnt_next;
      end
`else
      rr_ptr_d = gnt_next;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      rr_ptr_q     <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
`ifdef ALU_ARB_LOCK_EN
      lock_q       <= 1'b0;
      lock_id_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
`ifdef ALU_ARB_LOCK_EN
      lock_q       <= lock_d;
      lock_id_q    <= lock_id_d;
`endif
    end
  end

  assign rsp_valid  = (state_q == FULL);
  assign busy       = rsp_valid;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_srcA;
  logic [NREQ*XLEN-1:0] req_srcB;
  logic [NREQ*5-1:0]    req_ctrl;
`ifdef ALU_ARB_LOCK_EN
  logic [NREQ-1:0]      req_lock;
`endif
  logic [XLEN-1:0]      alu_srcA;
  logic [XLEN-1:0]      alu_srcB;
  logic [4:0]           alu_ctrl;
  logic [XLEN-1:0]      alu_result;
  logic [3:0]           alu_flags;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [XLEN-1:0]      rsp_result;
  logic [3:0]           rsp_flags;
  logic                 busy;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_srcA   (req_srcA),
    .req_srcB   (req_srcB),
    .req_ctrl   (req_ctrl),
`ifdef ALU_ARB_LOCK_EN
    .req_lock   (req_lock),
`endif
    .alu_srcA   (alu_srcA),
    .alu_srcB   (alu_srcB),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  // Stand-in for the shared combinational ALU.
  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_result = alu_srcA + alu_srcB;
      ALU_SUB: alu_result = alu_srcA - alu_srcB;
      default: alu_result = alu_srcA ^ alu_srcB;
    endcase
    alu_flags = {2'b00, alu_result[XLEN-1], alu_result == '0};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] c);
    req_srcA[i*XLEN +: XLEN] = a;
    req_srcB[i*XLEN +: XLEN] = b;
    req_ctrl[i*5 +: 5]       = c;
  endtask

  initial begin
    int exp_g;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_srcA  = '0;
    req_srcB  = '0;
    req_ctrl  = '0;
`ifdef ALU_ARB_LOCK_EN
    req_lock  = '0;
`endif
    tick();
    tick();
    check("rst_valid", rsp_valid, 0);
    check("rst_ready", req_ready, 0);
    check("rst_result", rsp_result, 0);
    check("rst_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // single op: 5+7
    set_req(0, 5, 7, ALU_ADD);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    #1;
    check("single_ready", req_ready, 2'b01);
    check("single_aluA", alu_srcA, 5);
    tick();
    req_valid = 2'b00;
    check("single_valid", rsp_valid, 1);
    check("single_id", rsp_id, 0);
    check("single_result", rsp_result, 12);
    check("single_zero", rsp_flags[0], 0);
    tick();
    check("drain_valid", rsp_valid, 0);
    check("drain_hold", rsp_result, 12);

    // round robin; pointer is 1 after the single op, so req1 goes first
    set_req(0, 1, 1, ALU_ADD);
    set_req(1, 3, 3, ALU_SUB);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 1 : 0;
      #1;
      check("rr_ready", req_ready, (exp_g == 1) ? 2'b10 : 2'b01);
      tick();
      check("rr_valid", rsp_valid, 1);
      check("rr_id", rsp_id, exp_g);
      check("rr_result", rsp_result, (exp_g == 1) ? 0 : 2);
      check("rr_zero", rsp_flags[0], (exp_g == 1) ? 1 : 0);
    end

    // backpressure: response id0/2 pending, req1 waits
    req_valid = 2'b10;
    rsp_ready = 1'b0;
    set_req(1, 10, 20, ALU_ADD);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready", req_ready, 2'b00);
      check("bp_valid", rsp_valid, 1);
      check("bp_id", rsp_id, 0);
      check("bp_result", rsp_result, 2);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", req_ready, 2'b10);
    tick();
    check("bp_new_valid", rsp_valid, 1);
    check("bp_new_id", rsp_id, 1);
    check("bp_new_result", rsp_result, 30);

    // fire req0 so the pointer moves to 1, then hold the response
    set_req(0, 4, 4, ALU_ADD);
    req_valid = 2'b01;
    #1;
    check("pre_rst_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    check("pre_rst_result", rsp_result, 8);
    tick();
    check("pre_rst_hold", rsp_valid, 1);

    // reset mid-flight
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_result", rsp_result, 0);
    check("mid_rst_id", rsp_id, 0);
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    set_req(1, 100, 1, ALU_ADD);
    req_valid = 2'b11;
    #1;
    check("post_rst_ptr", req_ready, 2'b01);
    tick();
    check("post_rst_id0", rsp_id, 0);
    check("post_rst_res0", rsp_result, 8);
    #1;
    check("post_rst_ready1", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check("post_rst_id1", rsp_id, 1);
    check("post_rst_res1", rsp_result, 101);
    tick();

`ifdef ALU_ARB_LOCK_EN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_req(0, 9, 1, ALU_SUB);
    req_valid = 2'b11;
    req_lock  = 2'b01;
    #1;
    check("lock_first", req_ready, 2'b01);
    tick();
    check("lock_res", rsp_result, 8);
    check("lock_id", rsp_id, 0);
    #1;
    check("lock_held", req_ready, 2'b01);
    tick();
    req_lock = 2'b00;
    #1;
    check("lock_release_fire", req_ready, 2'b01);
    tick();
    #1;
    check("lock_after", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    check("lock_after_id", rsp_id, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
